// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM states, bus mode constant, default word width
// and a counter-width helper. Also imported by the SPI responder.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        HOLD,
        GAP
    } spi_state_t;

    // {CPOL, CPHA} for the only supported bus mode
    localparam logic [1:0] SPI_MODE0 = 2'b00;

    localparam int SPI_DATA_W = 8;

    // Bits needed to hold the values 0..n
    function automatic int bits_for(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator. While enabled, it pulses tick once every CLK_DIV
// clk cycles. The count restarts on clear, while disabled, and after each tick,
// so it never wraps past its terminal value.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = bits_for(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = enable && (cnt == CNT_LAST);

    // Count clk cycles within the current half-period
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear || !enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI initiator with a valid/ready byte-stream interface. Words that are
// not marked tx_last keep SSEL low so that a burst forms a single frame.
// SCLK, SSEL and MOSI come straight from flops.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W  = SPI_DATA_W,
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_last,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              SCLK,
    output logic              SSEL,
    output logic              MOSI,
    input  logic              MISO
);

    localparam int BIT_W = bits_for(DATA_W);
    localparam int GAP_W = bits_for(CS_GAP);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    spi_state_t state;
    spi_state_t state_next;

    logic [DATA_W-1:0] shift_reg;
    logic              last_flag;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic div_en;
    logic div_tick;
    logic state_change;

    logic load;
    logic rise;
    logic fall;
    logic final_fall;
    logic ssel_release;

    assign tx_ready     = (state == IDLE) || (state == WAIT);
    assign busy         = (state != IDLE);
    assign div_en       = (state == SETUP) || (state == SHIFT) || (state == HOLD);
    assign state_change = (state_next != state);

    spi_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .rst   (rst),
        .enable(div_en),
        .clear (state_change),
        .tick  (div_tick)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus one-cycle strobes that steer the datapath flops.
    // The first SCLK rise is issued on leaving SETUP; the bit counter counts
    // falls, so the fall seen with bit_cnt at DATA_W-1 ends the word.
    always_comb begin
        state_next   = state;
        load         = 1'b0;
        rise         = 1'b0;
        fall         = 1'b0;
        final_fall   = 1'b0;
        ssel_release = 1'b0;
        case (state)
            IDLE, WAIT: begin
                if (tx_valid) begin
                    load       = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                if (div_tick) begin
                    rise       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (div_tick) begin
                    if (!SCLK) begin
                        rise = 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        final_fall = 1'b1;
                        state_next = last_flag ? HOLD : WAIT;
                    end else begin
                        fall = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (div_tick) begin
                    ssel_release = 1'b1;
                    state_next   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shift register, bus pins and receive word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SCLK      <= 1'b0;
            SSEL      <= 1'b1;
            MOSI      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            shift_reg <= '0;
            last_flag <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (load) begin
                shift_reg <= tx_data;
                last_flag <= tx_last;
                MOSI      <= tx_data[DATA_W-1];
                SSEL      <= 1'b0;
            end
            if (rise) begin
                SCLK      <= 1'b1;
                shift_reg <= {shift_reg[DATA_W-2:0], MISO};
            end
            if (fall) begin
                SCLK <= 1'b0;
                MOSI <= shift_reg[DATA_W-1];
            end
            if (final_fall) begin
                SCLK     <= 1'b0;
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
            end
            if (ssel_release) begin
                SSEL <= 1'b1;
                MOSI <= 1'b0;
            end
        end
    end

    // Bit and gap counters restart on every state entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else if (state_change) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
        end else begin
            if (fall) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
            if (state == GAP) begin
                gap_cnt <= gap_cnt + GAP_W'(1);
            end
        end
    end

endmodule
